// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the lane helpers used when driving the data memory port.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD,
    S_RDATA,
    S_SLEEP,
    S_WAKE
  } lsu_state_e;

  // funct3[1:0] encodes the access width for loads and stores alike
  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: request legality, byte enables, write replication
// and extraction of load data from the returned memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_write_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [1:0]  req_addr_lo_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  rd_funct3_i,
  input  logic [1:0]  rd_addr_lo_i,
  input  logic [31:0] mem_rdata_i,
  output logic        legal_o,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign mask_o  = byte_mask(req_funct3_i, req_addr_lo_i);
  assign wdata_o = replicate(req_funct3_i, req_wdata_i);

  always_comb begin
    legal_o = 1'b0;
    case (req_funct3_i)
      F3_B:    legal_o = 1'b1;
      F3_H:    legal_o = ~req_addr_lo_i[0];
      F3_W:    legal_o = (req_addr_lo_i == 2'b00);
      F3_BU:   legal_o = ~req_write_i;
      F3_HU:   legal_o = ~req_write_i & ~req_addr_lo_i[0];
      default: legal_o = 1'b0;
    endcase
  end

  // Halfwords are always 2-byte aligned here, so a byte-granular shift covers both widths
  always_comb begin
    shifted = mem_rdata_i >> {rd_addr_lo_i, 3'b000};
    case (rd_funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_o = {24'h0, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_o = {16'h0, shifted[15:0]};
      default: rdata_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store from execute, drives the SPRAM
// port, stalls across read latency and stand-by wake-up, returns extended data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        cpu_wfi,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_wfi,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  rd_funct3_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_mask_q;
  logic        mem_write_q, mem_read_q, mem_wfi_q;
  logic        rsp_valid_q, misaligned_q;

  logic        legal;
  logic [3:0]  mask;
  logic [31:0] wdata, rdata;

  lsu_align u_align (
    .req_write_i   (req_write),
    .req_funct3_i  (req_funct3),
    .req_addr_lo_i (req_addr[1:0]),
    .req_wdata_i   (req_wdata),
    .rd_funct3_i   (rd_funct3_q),
    .rd_addr_lo_i  (mem_addr_q[1:0]),
    .mem_rdata_i   (mem_rdata),
    .legal_o       (legal),
    .mask_o        (mask),
    .wdata_o       (wdata),
    .rdata_o       (rdata)
  );

  // A request still visible while its response is out is the one completing, not a new one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      rd_funct3_q  <= 3'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_mask_q   <= 4'd0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_wfi_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && !rsp_valid_q) begin
            if (legal) begin
              mem_addr_q  <= req_addr;
              mem_mask_q  <= mask;
              mem_wdata_q <= wdata;
              rd_funct3_q <= req_funct3;
              if (req_write) begin
                mem_write_q <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= S_STORE;
              end else begin
                mem_read_q <= 1'b1;
                state_q    <= S_LOAD;
              end
            end else begin
              rsp_valid_q  <= 1'b1;
              misaligned_q <= 1'b1;
            end
          end else if (cpu_wfi && !req_valid) begin
            mem_wfi_q <= 1'b1;
            state_q   <= S_SLEEP;
          end
        end
        S_STORE: state_q <= S_IDLE;
        S_LOAD: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_RDATA;
        end
        S_RDATA: state_q <= S_IDLE;
        S_SLEEP: begin
          if (req_valid || !cpu_wfi) begin
            mem_wfi_q <= 1'b0;
            cnt_q     <= 4'(WAKE_CYCLES);
            state_q   <= S_WAKE;
          end
        end
        S_WAKE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall      = req_valid & ~rsp_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign misaligned = misaligned_q;
  assign rsp_rdata  = (state_q == S_RDATA) ? rdata : 32'd0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mask   = mem_mask_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;
  assign mem_wfi    = mem_wfi_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses compared against an arithmetic model of the memory port behaviour.
module tb_load_store_unit;

  localparam int unsigned WAKE = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, cpu_wfi;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        stall, rsp_valid, misaligned, mem_write, mem_read, mem_wfi;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .cpu_wfi(cpu_wfi), .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misaligned(misaligned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_write(mem_write), .mem_read(mem_read),
    .mem_wfi(mem_wfi), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, then plain arithmetic on byte lanes
  function automatic int refSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit refLegal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (wr && f3 > 3'd2) return 1'b0;
    if (!wr && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
    return (int'(a[1:0]) % refSize(f3)) == 0;
  endfunction

  function automatic logic [3:0] refMask(input logic [2:0] f3, input logic [31:0] a);
    int sz, off;
    sz  = refSize(f3);
    off = int'(a[1:0]) - (int'(a[1:0]) % sz);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = refSize(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] refRdata(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    longint v;
    int bits;
    bits = 8 * refSize(f3);
    v = (longint'(word) >> (8 * int'(a[1:0]))) & ((64'sd1 <<< bits) - 1);
    if (!f3[2] && bits < 32 && v[bits-1]) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  // One complete access starting from an idle unit; checks every cycle of it
  task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] word, input string tag);
    bit ok;
    ok = refLegal(wr, f3, a);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_rdata = $urandom;
    #1;
    checkOutput({tag, ".stallT"}, 32'(stall), 32'd1);
    tick();
    if (!ok) begin
      checkOutput({tag, ".rspValid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, ".misaligned"}, 32'(misaligned), 32'd1);
      checkOutput({tag, ".rdataZero"}, rsp_rdata, 32'd0);
      checkOutput({tag, ".noStrobe"}, {30'd0, mem_write, mem_read}, 32'd0);
      req_valid = 1'b0;
      tick();
      checkOutput({tag, ".rspDone"}, {30'd0, rsp_valid, mem_read | mem_write}, 32'd0);
    end else if (wr) begin
      checkOutput({tag, ".write"}, {30'd0, mem_write, mem_read}, 32'd2);
      checkOutput({tag, ".rspValid"}, {30'd0, rsp_valid, misaligned}, 32'd2);
      checkOutput({tag, ".stall"}, 32'(stall), 32'd0);
      checkOutput({tag, ".addr"}, mem_addr, a);
      checkOutput({tag, ".mask"}, 32'(mem_mask), 32'(refMask(f3, a)));
      checkOutput({tag, ".wdata"}, mem_wdata, refWdata(f3, wd));
      req_valid = 1'b0;
      tick();
      checkOutput({tag, ".oneShot"}, {30'd0, mem_write, rsp_valid}, 32'd0);
    end else begin
      checkOutput({tag, ".read"}, {30'd0, mem_write, mem_read}, 32'd1);
      checkOutput({tag, ".noRsp"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".stallLoad"}, 32'(stall), 32'd1);
      checkOutput({tag, ".addr"}, mem_addr, a);
      checkOutput({tag, ".mask"}, 32'(mem_mask), 32'(refMask(f3, a)));
      mem_rdata = word;
      tick();
      checkOutput({tag, ".rspValid"}, {30'd0, rsp_valid, misaligned}, 32'd2);
      checkOutput({tag, ".rdata"}, rsp_rdata, refRdata(f3, a, word));
      checkOutput({tag, ".readOnce"}, 32'(mem_read), 32'd0);
      checkOutput({tag, ".stallDone"}, 32'(stall), 32'd0);
      req_valid = 1'b0;
      mem_rdata = $urandom;
      tick();
      checkOutput({tag, ".rspOnce"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; cpu_wfi = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    checkOutput("reset.strobes", {26'd0, rsp_valid, misaligned, mem_write, mem_read, mem_wfi, stall}, 32'd0);
    checkOutput("reset.addr", mem_addr, 32'd0);
    checkOutput("reset.wdata", mem_wdata, 32'd0);
    checkOutput("reset.mask", 32'(mem_mask), 32'd0);
    checkOutput("reset.rdata", rsp_rdata, 32'd0);
    req_valid = 1'b1;
    #1;
    checkOutput("reset.stallFollowsReq", 32'(stall), 32'd1);
    req_valid = 1'b0;
    rst = 1'b0;
    tick();

    applyStimulus(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, "SB");
    applyStimulus(1'b0, 3'b000, 32'h0000_0102, 32'd0, 32'h0080_0000, "LB");
    applyStimulus(1'b0, 3'b100, 32'h0000_0102, 32'd0, 32'h0080_0000, "LBU");
    applyStimulus(1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h8001_1234, "LH");
    applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h8001_1234, "LHU");
    applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'hDEAD_BEEF, "LWmis");
    applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'd0, "SH");
    applyStimulus(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'd0, "SW");
    applyStimulus(1'b1, 3'b100, 32'h0000_0300, 32'h1, 32'd0, "SBUbad");
    applyStimulus(1'b0, 3'b110, 32'h0000_0300, 32'd0, 32'h1, "LF3bad");

    // Stand-by: memory sleeps while the core is idle, wakes for a pending load
    cpu_wfi = 1'b1;
    tick();
    checkOutput("wfi.enter", {30'd0, mem_wfi, stall}, 32'd2);
    repeat (4) tick();
    checkOutput("wfi.hold", 32'(mem_wfi), 32'd1);
    cpu_wfi = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_2000;
    #1;
    checkOutput("wfi.stall", 32'(stall), 32'd1);
    tick();
    checkOutput("wfi.drop", {30'd0, mem_wfi, mem_read}, 32'd0);
    n = 1;
    while (!mem_read && n < 20) begin
      tick();
      n++;
    end
    checkOutput("wfi.readLatency", 32'(n), 32'(WAKE + 2));
    checkOutput("wfi.mask", 32'(mem_mask), 32'hF);
    mem_rdata = 32'h1357_9BDF;
    tick();
    checkOutput("wfi.rsp", {31'd0, rsp_valid}, 32'd1);
    checkOutput("wfi.rdata", rsp_rdata, 32'h1357_9BDF);
    req_valid = 1'b0;
    tick();

    // Reset in the middle of a load throws the response away
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0400;
    tick();
    checkOutput("rstMid.read", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstMid.clear", {26'd0, rsp_valid, misaligned, mem_write, mem_read, mem_wfi, stall}, 32'd1);
    checkOutput("rstMid.addr", mem_addr, 32'd0);
    checkOutput("rstMid.rdata", rsp_rdata, 32'd0);
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rstMid.noRsp", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0404, 32'd0, 32'h0BAD_F00D, "LWafter");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                     $urandom, $urandom, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
